player_pos_tx: RTL
==================

PLAYER_POS_TX -- requirements
Module: player_pos_tx

Interface
REQ-001 Parameter CLK_FREQ, default 65_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; DIV = CLK_FREQ/BAUD with integer truncation (564 at defaults).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 xpos  input  12  limited player x position.
REQ-006 ypos  input  12  limited player y position.
REQ-007 click  input  1  player click/jump flag.
REQ-008 send  input  1  request strobe; sampled every cycle.
REQ-009 tx  output  1  UART serial line, idle high.
REQ-010 busy  output  1  high while a packet is in flight.
REQ-011 done  output  1  one-cycle pulse at packet completion.

Function
REQ-012 Frame format SHALL be UART 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly DIV cycles.
REQ-013 Packet SHALL be bytes in order: B0=0xA5, B1=xpos[7:0], B2={ypos[3:0],xpos[11:8]}, B3=ypos[11:4], B4={7'b0,click}.
REQ-014 Bytes SHALL be sent back-to-back: the next start bit begins the cycle after the previous stop bit's DIV cycles end.
REQ-015 State machine SHALL have states IDLE, START, DATA, STOP, with a byte index counter and a 3-bit bit index counter.
REQ-016 IDLE->START when send=1 in IDLE; xpos, ypos and click SHALL be captured into shadow registers in that same cycle.
REQ-017 tx SHALL go low and busy high on the first clock edge after the cycle in which send was sampled high (1-cycle latency).
REQ-018 START->DATA after DIV cycles; DATA->STOP after 8 bits; STOP->START if bytes remain, else STOP->IDLE.
REQ-019 On STOP->IDLE, done SHALL be 1 for exactly one cycle, and busy SHALL fall in that same cycle.
REQ-020 send while busy=1 SHALL be ignored, with no queuing, and input changes while busy SHALL not affect the packet in flight.
REQ-021 send=1 in the same cycle done=1 SHALL be ignored; a send asserted one cycle later SHALL start a new packet.
REQ-022 The baud counter SHALL count 0..DIV-1 and wrap; bit and byte counters SHALL reset to 0 on entering START from IDLE.
REQ-023 tx SHALL be driven from a register (glitch-free).

Reset
REQ-024 rst=1 SHALL force state=IDLE, tx=1, busy=0, done=0 and clear all counters and shadow registers on the next edge.
REQ-025 rst asserted mid-packet SHALL abort the packet: tx=1 after the next edge, no done pulse, and send SHALL be ignored while rst=1.

Configuration
REQ-026 Macro PLAYER_POS_TX_CHECKSUM_EN, when defined, SHALL append byte B5 = B1^B2^B3^B4 after B4; the packet is then 6 bytes.
REQ-027 Without PLAYER_POS_TX_CHECKSUM_EN, the packet SHALL be exactly 5 bytes and no checksum logic SHALL be synthesized.

Verification (CLK_FREQ=1000, BAUD=100, so DIV=10)
REQ-028 rst for 2 cycles, then idle -> tx=1, busy=0, done=0 continuously.
REQ-029 xpos=0x1AB, ypos=0x2C7, click=1, one send pulse -> bytes A5,AB,71,2C,01 on tx, each bit 10 cycles; busy high 500 cycles (5 bytes x 10 bits x DIV); done pulses once; with macro defined, extra byte F7 and 600 cycles.
REQ-030 After the REQ-029 send is captured, change xpos to 0x3FF and pulse send at cycle 100 -> transmitted bytes unchanged, and no second packet follows.
REQ-031 Pulse send in the done cycle -> ignored; pulse send the next cycle -> tx low one cycle later.
REQ-032 Assert rst at cycle 250 of a packet -> tx=1 and busy=0 after the next edge, no done pulse; a send after rst releases transmits a full correct packet.
REQ-033 xpos=0, ypos=0, click=0 -> bytes A5,00,00,00,00, with the checksum byte 00 when the macro is defined.

Source files
------------

// File: rtl/player_pos_tx_if.sv
// Bus bundle for player_pos_tx: position/click inputs, send strobe, UART line and status.
// master drives the request side; slave is the transmitter.
interface player_pos_tx_if;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        click;
    logic        send;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (
        output xpos, ypos, click, send,
        input  tx, busy, done
    );

    modport slave (
        input  xpos, ypos, click, send,
        output tx, busy, done
    );
endinterface

// File: rtl/player_pos_tx.sv
// UART 8N1 transmitter for a player position packet: A5, x[7:0], {y[3:0],x[11:8]}, y[11:4], click.
// Define PLAYER_POS_TX_CHECKSUM_EN to append an XOR checksum byte over bytes 1..4.
module player_pos_tx #(
    parameter int CLK_FREQ = 65_000_000,
    parameter int BAUD     = 115200
) (
    input  logic           clk,
    input  logic           rst,
    player_pos_tx_if.slave bus
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
`ifdef PLAYER_POS_TX_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd5;
`else
    localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [2:0]       byte_idx, byte_idx_n;
    logic [11:0]      xpos_sh, ypos_sh;
    logic             click_sh;
    logic             tx_q, tx_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             capture;
    logic             bit_end;
    logic [7:0]       cur_byte;

    assign bit_end = (baud_cnt == CNT_LAST);

    always_comb begin
        cur_byte = 8'hA5;
        case (byte_idx)
            3'd0:    cur_byte = 8'hA5;
            3'd1:    cur_byte = xpos_sh[7:0];
            3'd2:    cur_byte = {ypos_sh[3:0], xpos_sh[11:8]};
            3'd3:    cur_byte = ypos_sh[11:4];
            3'd4:    cur_byte = {7'd0, click_sh};
`ifdef PLAYER_POS_TX_CHECKSUM_EN
            3'd5:    cur_byte = xpos_sh[7:0] ^ {ypos_sh[3:0], xpos_sh[11:8]}
                                ^ ypos_sh[11:4] ^ {7'd0, click_sh};
`endif
            default: cur_byte = 8'hA5;
        endcase
    end

    // Next-state and registered-output logic; tx/busy/done are computed one cycle ahead
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        byte_idx_n = byte_idx;
        tx_n       = tx_q;
        busy_n     = busy_q;
        done_n     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                // A send coinciding with the completion pulse is dropped
                if (bus.send && !done_q) begin
                    state_n    = START;
                    capture    = 1'b1;
                    baud_cnt_n = '0;
                    bit_idx_n  = 3'd0;
                    byte_idx_n = 3'd0;
                    tx_n       = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n    = DATA;
                    baud_cnt_n = '0;
                    bit_idx_n  = 3'd0;
                    tx_n       = cur_byte[0];
                end else begin
                    baud_cnt_n = baud_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        tx_n = cur_byte[bit_idx_n];
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = 3'd0;
                    if (byte_idx == LAST_BYTE) begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n    = START;
                        byte_idx_n = byte_idx + 3'd1;
                        tx_n       = 1'b0;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            xpos_sh  <= 12'd0;
            ypos_sh  <= 12'd0;
            click_sh <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            byte_idx <= byte_idx_n;
            tx_q     <= tx_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            if (capture) begin
                xpos_sh  <= bus.xpos;
                ypos_sh  <= bus.ypos;
                click_sh <= bus.click;
            end
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
